// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : mem_arbiter_pkg
// Description : Shared FSM state encoding and data-port request codes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_BUSY_IF = 2'd1;
    localparam logic [1:0] c_ST_BUSY_D  = 2'd2;

    // Same encoding as the decoder's mem_rw output; 2'b11 is treated as no request.
    localparam logic [1:0] c_RW_NONE  = 2'b00;
    localparam logic [1:0] c_RW_LOAD  = 2'b01;
    localparam logic [1:0] c_RW_STORE = 2'b10;

    function automatic logic rw_is_access(input logic [1:0] rw);
        return (rw == c_RW_LOAD) || (rw == c_RW_STORE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : mem_timeout_ctr
// Description : Busy-cycle wait counter flagging the last allowed cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int c_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + c_W'(1);
        end
    end

    assign expired = (r_count == c_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : mem_arbiter
// Description : Fetch/data arbiter onto a single memory port with timeout.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic [1:0]  d_mem_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int c_SW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]      r_state;
    logic [c_SW-1:0] r_starve;

    logic w_busy;
    logic w_d_pend;
    logic w_idle_ok;
    logic w_starved;
    logic w_grant_if;
    logic w_grant_d;
    logic w_ack;
    logic w_expired;
    logic w_timeout;

    assign w_busy    = (r_state == c_ST_BUSY_IF) || (r_state == c_ST_BUSY_D);
    assign w_d_pend  = rw_is_access(d_mem_rw);
    // Requesters still see their done pulse this cycle, so nothing is granted yet.
    assign w_idle_ok = (r_state == c_ST_IDLE) && !if_done && !d_done;
    assign w_starved = (r_starve == c_SW'(STARVE_LIMIT));

    assign w_grant_if = w_idle_ok && if_req && (w_starved || !w_d_pend);
    assign w_grant_d  = w_idle_ok && w_d_pend && !w_grant_if;
    assign w_ack      = w_busy && mem_ack;
    assign w_timeout  = w_busy && !mem_ack && w_expired;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_grant_if || w_grant_d),
        .inc     (w_busy && !mem_ack),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_starve  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_if) begin
                        r_state   <= c_ST_BUSY_IF;
                        r_starve  <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end else if (w_grant_d) begin
                        r_state   <= c_ST_BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= (d_mem_rw == c_RW_STORE);
                        mem_addr  <= d_addr;
                        mem_wdata <= (d_mem_rw == c_RW_STORE) ? d_wdata : '0;
                        if (if_req && !w_starved) begin
                            r_starve <= r_starve + c_SW'(1);
                        end
                    end
                end
                c_ST_BUSY_IF, c_ST_BUSY_D: begin
                    // An ack arriving on the last allowed cycle wins over the timeout.
                    if (w_ack || w_timeout) begin
                        r_state <= c_ST_IDLE;
                        mem_req <= 1'b0;
                        err     <= w_timeout;
                        if (r_state == c_ST_BUSY_IF) begin
                            if_done  <= 1'b1;
                            if_rdata <= w_ack ? mem_rdata : '0;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= (w_ack && !mem_we) ? mem_rdata : '0;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench with a cycle-level reference model.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic [1:0]  d_mem_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_mem_rw  (d_mem_rw),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // ---------------- reference model ----------------
    // owner: 0 = nobody, 1 = fetch, 2 = data; waited counts busy cycles so far.
    int          m_owner  = 0;
    int          m_waited = 0;
    int          m_starve = 0;
    bit          m_blocked, m_ld, m_st, m_timed;
    logic        e_req = 0, e_we = 0, e_if_done = 0, e_d_done = 0, e_err = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_if_rdata = 0, e_d_rdata = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = 0; m_waited = 0; m_starve = 0;
            e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
            e_if_done = 0; e_d_done = 0; e_err = 0; e_if_rdata = 0; e_d_rdata = 0;
        end else begin
            m_blocked = e_if_done || e_d_done;
            e_if_done = 0; e_d_done = 0; e_err = 0;
            if (m_owner == 0) begin
                m_ld = (d_mem_rw == 2'b01);
                m_st = (d_mem_rw == 2'b10);
                if (!m_blocked && if_req && (m_starve >= STARVE_LIMIT || !(m_ld || m_st))) begin
                    m_owner = 1; m_waited = 0; m_starve = 0;
                    e_req = 1; e_we = 0; e_addr = if_addr; e_wdata = 0;
                end else if (!m_blocked && (m_ld || m_st)) begin
                    m_owner = 2; m_waited = 0;
                    if (if_req && m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
                    e_req = 1; e_we = m_st; e_addr = d_addr; e_wdata = m_st ? d_wdata : 0;
                end
            end else begin
                m_waited = m_waited + 1;
                if (mem_ack || m_waited == TIMEOUT) begin
                    m_timed = !mem_ack;
                    e_req = 0; e_err = m_timed;
                    if (m_owner == 1) begin
                        e_if_done = 1; e_if_rdata = m_timed ? 32'h0 : mem_rdata;
                    end else begin
                        e_d_done = 1; e_d_rdata = (m_timed || e_we) ? 32'h0 : mem_rdata;
                    end
                    m_owner = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus-side state ----------------
    logic [1:0]  dq_rw   [0:31];
    logic [31:0] dq_addr [0:31];
    logic [31:0] dq_wdata[0:31];
    int          n_issued = 0, d_idx = 0, cur = 0;
    int          if_issued = 0, if_served = 0;
    bit          d_active = 0, abort = 0, force_ack = 0;
    logic [1:0]  raw_rw = 2'b00;
    logic [31:0] fetch_addr = 32'h0, rdata_val = 32'h0;
    int          ack_at = 0, busy_n = 0, cyc = 0;

    // grant and completion logs
    bit          prev_req = 0;
    int          gn = 0, dn = 0;
    logic        g_we [0:63];
    logic [31:0] g_addr[0:63];
    int          g_len [0:63];
    int          g_rise[0:63];
    logic        dn_if [0:63];
    logic        dn_err[0:63];
    logic [31:0] dn_rd [0:63];

    task automatic issue_d(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] w);
        dq_rw[n_issued] = rw; dq_addr[n_issued] = a; dq_wdata[n_issued] = w;
        n_issued++;
    endtask

    task automatic driver_loop();
        forever begin
            @(negedge clk);
            if (abort) begin d_active = 0; d_idx = n_issued; if_served = if_issued; end
            if (d_active && d_done) d_active = 0;
            if (if_served != if_issued && if_req && if_done) if_served++;
            if (!d_active && d_idx != n_issued) begin d_active = 1; cur = d_idx; d_idx++; end
            d_mem_rw = d_active ? dq_rw[cur]    : raw_rw;
            d_addr   = d_active ? dq_addr[cur]  : 32'h0;
            d_wdata  = d_active ? dq_wdata[cur] : 32'h0;
            if_req   = (if_served != if_issued);
            if_addr  = fetch_addr;
        end
    endtask

    task automatic responder_loop();
        forever begin
            @(negedge clk);
            if (mem_req) begin
                busy_n++;
                mem_ack = force_ack || (ack_at != 0 && busy_n == ack_at);
            end else begin
                busy_n  = 0;
                mem_ack = force_ack;
            end
            mem_rdata = rdata_val;
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_req && !prev_req && gn < 64) begin
                g_we[gn] = mem_we; g_addr[gn] = mem_addr; g_len[gn] = 1; g_rise[gn] = cyc;
                gn++;
            end else if (mem_req && gn > 0) begin
                g_len[gn-1]++;
            end
            prev_req = mem_req;
            if ((if_done || d_done) && dn < 64) begin
                dn_if[dn] = if_done; dn_err[dn] = err;
                dn_rd[dn] = if_done ? if_rdata : d_rdata;
                dn++;
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (check_en) begin
                check("mem_req", mem_req, e_req);
                check("if_done", if_done, e_if_done);
                check("d_done",  d_done,  e_d_done);
                check("err",     err,     e_err);
                if (e_req) begin
                    check("mem_we",    mem_we,    e_we);
                    check("mem_addr",  mem_addr,  e_addr);
                    check("mem_wdata", mem_wdata, e_wdata);
                end
                if (e_if_done) check("if_rdata", if_rdata, e_if_rdata);
                if (e_d_done)  check("d_rdata",  d_rdata,  e_d_rdata);
            end
        end
    endtask

    task automatic wait_quiet(input string name, input int max);
        int  n = 0;
        bit  quiet = 0;
        while (n < max && !quiet) begin
            tick();
            n++;
            quiet = !d_active && d_idx == n_issued && if_served == if_issued && !mem_req;
        end
        check({name, "_quiet"}, quiet, 1'b1);
        tick();
        tick();
    endtask

    int gb, db;

    initial begin
        rst = 1; if_req = 0; if_addr = 0; d_mem_rw = 0; d_addr = 0; d_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        fork
            driver_loop();
            responder_loop();
            monitor_loop();
            compare_loop();
        join_none

        tick(); tick(); tick();
        check_en = 1;
        check("rst_mem_req",   mem_req,   1'b0);
        check("rst_mem_we",    mem_we,    1'b0);
        check("rst_mem_addr",  mem_addr,  32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_if_done",   if_done,   1'b0);
        check("rst_d_done",    d_done,    1'b0);
        check("rst_err",       err,       1'b0);
        check("rst_if_rdata",  if_rdata,  32'h0);
        check("rst_d_rdata",   d_rdata,   32'h0);
        rst = 0;
        tick();

        // Single load, ack on the 2nd busy cycle
        gb = gn; db = dn;
        ack_at = 2; rdata_val = 32'hDEADBEEF;
        issue_d(2'b01, 32'h100, 32'h0);
        wait_quiet("load", 40);
        check("load_grants", gn - gb, 1);
        check("load_addr",   g_addr[gb], 32'h100);
        check("load_we",     g_we[gb], 1'b0);
        check("load_len",    g_len[gb], 2);
        check("load_rdata",  dn_rd[db], 32'hDEADBEEF);
        check("load_err",    dn_err[db], 1'b0);

        // Store and fetch together: store first, fetch after d_done
        gb = gn; db = dn;
        ack_at = 1; rdata_val = 32'hA5A5_0001; fetch_addr = 32'h200;
        issue_d(2'b10, 32'h40, 32'h12345678);
        if_issued++;
        wait_quiet("contend", 40);
        check("cont_grants",  gn - gb, 2);
        check("cont_g0_we",   g_we[gb], 1'b1);
        check("cont_g0_addr", g_addr[gb], 32'h40);
        check("cont_g1_addr", g_addr[gb+1], 32'h200);
        check("cont_spacing", g_rise[gb+1] - g_rise[gb], 3);
        check("cont_d_first", dn_if[db], 1'b0);
        check("cont_st_rd",   dn_rd[db], 32'h0);
        check("cont_if_rd",   dn_rd[db+1], 32'hA5A5_0001);

        // Starvation: 5 loads vs a held fetch
        gb = gn;
        ack_at = 1; rdata_val = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) issue_d(2'b01, 32'h10 + 32'(4 * i), 32'h0);
        if_issued++;
        wait_quiet("starve", 80);
        check("stv_grants", gn - gb, 6);
        check("stv_g0", g_addr[gb],   32'h10);
        check("stv_g3", g_addr[gb+3], 32'h1C);
        check("stv_g4", g_addr[gb+4], 32'h200);
        check("stv_g5", g_addr[gb+5], 32'h20);

        // Fetch timeout
        gb = gn; db = dn;
        ack_at = 0; rdata_val = 32'hFFFF_FFFF;
        if_issued++;
        wait_quiet("timeout", 60);
        check("to_len",   g_len[gb], 16);
        check("to_is_if", dn_if[db], 1'b1);
        check("to_err",   dn_err[db], 1'b1);
        check("to_rdata", dn_rd[db], 32'h0);

        // Ack on the final allowed cycle counts as ack
        gb = gn; db = dn;
        ack_at = 16; rdata_val = 32'hCAFEF00D;
        issue_d(2'b01, 32'h300, 32'h0);
        wait_quiet("edge", 60);
        check("edge_len",   g_len[gb], 16);
        check("edge_err",   dn_err[db], 1'b0);
        check("edge_rdata", dn_rd[db], 32'hCAFEF00D);

        // d_mem_rw = 11 and stray acks are ignored
        gb = gn; db = dn;
        ack_at = 0; raw_rw = 2'b11; force_ack = 1;
        for (int i = 0; i < 8; i++) tick();
        check("rw11_req",    mem_req, 1'b0);
        check("rw11_grants", gn - gb, 0);
        check("rw11_dones",  dn - db, 0);
        raw_rw = 2'b00; force_ack = 0;
        tick(); tick();

        // Reset in the 2nd busy cycle, late ack afterwards
        gb = gn; db = dn;
        issue_d(2'b01, 32'h500, 32'h0);
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        check("rsta_granted", mem_req, 1'b1);
        tick();
        rst = 1; abort = 1;
        tick();
        rst = 0; force_ack = 1; abort = 0;
        check("rsta_req", mem_req, 1'b0);
        tick();
        check("rsta_req2",  mem_req, 1'b0);
        check("rsta_ddone", d_done,  1'b0);
        check("rsta_err",   err,     1'b0);
        force_ack = 0;
        tick(); tick(); tick();
        check("rsta_grants", gn - gb, 1);
        check("rsta_dones",  dn - db, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
